ttt_turn_scheduler: RTL and testbench

Turn sequencer and move arbiter for the 4x4 tic-tac-toe game. It takes move requests from the player (`play`/`player_position`) and the computer (`pc`/`computer_position`), enforces strict alternation and cell vacancy, and issues single-cycle write commands to the board register file. It then samples the board's winner output and ends the game on a win or draw. It sits between the request sources and the board/win-check datapath; the board no longer decides turn order itself.

---
 rtl/ttt_turn_scheduler.sv | 177 +++++++++++++++++
 tb/tb_ttt_turn_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_scheduler.sv
// ---------------------------------------------------------------------------
// ttt_turn_scheduler
//
// Turn sequencer and move arbiter for the 4x4 tic-tac-toe game. Accepts
// rising-edge move requests from the player and the computer, enforces strict
// alternation and cell vacancy, issues one-cycle write commands to the board
// register file, then samples the board's winner output to end the game.
//
// Parameters
//   TIMEOUT_CYCLES  cycles a side may idle in WAIT before forfeiting its turn
//                   (0 disables the timeout)
//   FIRST_MOVER     side to move after reset: 0 = player, 1 = computer
//
// Ports
//   clock              in   system clock, rising edge
//   reset              in   asynchronous active-high reset
//   play / pc          in   player / computer move request (level, edge acts)
//   player_position    in   player target cell 0..15
//   computer_position  in   computer target cell 0..15
//   board              in   cell i at [2i+1:2i]; 00 empty, 01 player, 10 computer
//   who                in   00 none, 01 player wins, 10 computer wins, 11 draw
//   wr_en              out  one-cycle board write strobe
//   wr_pos             out  cell to write
//   wr_val             out  value to write: 01 player, 10 computer
//   turn               out  side to move: 0 = player, 1 = computer
//   illegal            out  one-cycle pulse on a rejected request
//   timeout            out  one-cycle pulse when a turn is forfeited
//   game_over          out  high from game end until reset
//   move_count         out  committed moves, 0..16
// ---------------------------------------------------------------------------
module ttt_turn_scheduler #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit FIRST_MOVER    = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        play,
    input  logic        pc,
    input  logic [3:0]  player_position,
    input  logic [3:0]  computer_position,
    input  logic [31:0] board,
    input  logic [1:0]  who,
    output logic        wr_en,
    output logic [3:0]  wr_pos,
    output logic [1:0]  wr_val,
    output logic        turn,
    output logic        illegal,
    output logic        timeout,
    output logic        game_over,
    output logic [4:0]  move_count
);

    localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [4:0]         MAX_MOVES  = 5'd16;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_COMMIT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic               play_q, pc_q;
    logic [TIMER_W-1:0] timer, timer_nxt;

    logic               turn_nxt, wr_en_nxt, illegal_nxt, timeout_nxt, game_over_nxt;
    logic [3:0]         wr_pos_nxt;
    logic [1:0]         wr_val_nxt;
    logic [4:0]         move_count_nxt;

    logic               play_req, pc_req, on_req, off_req, cell_free;
    logic [3:0]         on_pos;

    // Request decode: on_req belongs to the side whose turn it is.
    assign play_req  = play & ~play_q;
    assign pc_req    = pc & ~pc_q;
    assign on_req    = turn ? pc_req : play_req;
    assign off_req   = turn ? play_req : pc_req;
    assign on_pos    = turn ? computer_position : player_position;
    assign cell_free = (board[{on_pos, 1'b0} +: 2] == 2'b00);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other register in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_WAIT;
            play_q     <= 1'b0;
            pc_q       <= 1'b0;
            timer      <= '0;
            turn       <= FIRST_MOVER;
            wr_en      <= 1'b0;
            wr_pos     <= 4'd0;
            wr_val     <= 2'b00;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
            game_over  <= 1'b0;
            move_count <= 5'd0;
        end else begin
            state      <= state_nxt;
            play_q     <= play;
            pc_q       <= pc;
            timer      <= timer_nxt;
            turn       <= turn_nxt;
            wr_en      <= wr_en_nxt;
            wr_pos     <= wr_pos_nxt;
            wr_val     <= wr_val_nxt;
            illegal    <= illegal_nxt;
            timeout    <= timeout_nxt;
            game_over  <= game_over_nxt;
            move_count <= move_count_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        turn_nxt       = turn;
        wr_en_nxt      = 1'b0;
        wr_pos_nxt     = wr_pos;
        wr_val_nxt     = wr_val;
        illegal_nxt    = 1'b0;
        timeout_nxt    = 1'b0;
        game_over_nxt  = game_over;
        move_count_nxt = move_count;

        case (state)
            ST_WAIT: begin
                if (on_req && cell_free) begin
                    // Accepted move wins over a timeout expiring this cycle.
                    state_nxt   = ST_COMMIT;
                    wr_en_nxt   = 1'b1;
                    wr_pos_nxt  = on_pos;
                    wr_val_nxt  = turn ? 2'b10 : 2'b01;
                    timer_nxt   = '0;
                    illegal_nxt = off_req;
                    if (move_count != MAX_MOVES)
                        move_count_nxt = move_count + 5'd1;
                end else begin
                    // A single pulse covers an occupied-cell and an off-turn reject.
                    illegal_nxt = on_req | off_req;
                    if (TIMEOUT_CYCLES > 0) begin
                        if (timer == TIMER_LAST) begin
                            timeout_nxt = 1'b1;
                            turn_nxt    = ~turn;
                            timer_nxt   = '0;
                        end else begin
                            timer_nxt = timer + TIMER_W'(1);
                        end
                    end
                end
            end

            // Requests during COMMIT and SETTLE are silently discarded.
            ST_COMMIT: state_nxt = ST_SETTLE;

            ST_SETTLE: begin
                // The board has held the new value for a full cycle here.
                if (who != 2'b00 || move_count == MAX_MOVES) begin
                    state_nxt     = ST_DONE;
                    game_over_nxt = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                    turn_nxt  = ~turn;
                end
            end

            ST_DONE: illegal_nxt = play_req | pc_req;

            default: state_nxt = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ttt_turn_scheduler
//
// Drives two schedulers from shared request inputs: dut0 (player first,
// 15-cycle timeout) and dut1 (computer first, 4-cycle timeout). Each has its
// own board register file and win checker in the bench. A behavioural model
// per instance predicts every output each cycle; directed scenarios add
// end-of-game and timing checks on top of randomized play.
// ---------------------------------------------------------------------------
module tb_ttt_turn_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        play  = 1'b0;
    logic        pc    = 1'b0;
    logic [3:0]  player_position   = 4'd0;
    logic [3:0]  computer_position = 4'd0;

    logic [31:0] board0 = '0, board1 = '0;
    logic [1:0]  who0, who1;

    logic        wr_en0, wr_en1;
    logic [3:0]  wr_pos0, wr_pos1;
    logic [1:0]  wr_val0, wr_val1;
    logic        turn0, turn1, illegal0, illegal1, timeout0, timeout1;
    logic        game_over0, game_over1;
    logic [4:0]  move_count0, move_count1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ttt_turn_scheduler #(.TIMEOUT_CYCLES(15), .FIRST_MOVER(1'b0)) dut0 (
        .clock(clock), .reset(reset), .play(play), .pc(pc),
        .player_position(player_position), .computer_position(computer_position),
        .board(board0), .who(who0),
        .wr_en(wr_en0), .wr_pos(wr_pos0), .wr_val(wr_val0), .turn(turn0),
        .illegal(illegal0), .timeout(timeout0), .game_over(game_over0),
        .move_count(move_count0)
    );

    ttt_turn_scheduler #(.TIMEOUT_CYCLES(4), .FIRST_MOVER(1'b1)) dut1 (
        .clock(clock), .reset(reset), .play(play), .pc(pc),
        .player_position(player_position), .computer_position(computer_position),
        .board(board1), .who(who1),
        .wr_en(wr_en1), .wr_pos(wr_pos1), .wr_val(wr_val1), .turn(turn1),
        .illegal(illegal1), .timeout(timeout1), .game_over(game_over1),
        .move_count(move_count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- board environment: win / draw detection ----------------
    function automatic bit line4(input logic [31:0] b, input int a0, input int a1,
                                 input int a2, input int a3, input logic [1:0] s);
        return b[2*a0 +: 2] == s && b[2*a1 +: 2] == s && b[2*a2 +: 2] == s && b[2*a3 +: 2] == s;
    endfunction

    function automatic logic [1:0] win_of(input logic [31:0] b);
        logic [1:0] s;
        bit         full;
        for (int k = 1; k <= 2; k++) begin
            s = 2'(k);
            for (int r = 0; r < 4; r++) begin
                if (line4(b, 4*r, 4*r+1, 4*r+2, 4*r+3, s)) return s;
                if (line4(b, r, r+4, r+8, r+12, s))       return s;
            end
            if (line4(b, 0, 5, 10, 15, s)) return s;
            if (line4(b, 3, 6, 9, 12, s))  return s;
        end
        full = 1'b1;
        for (int i = 0; i < 16; i++)
            if (b[2*i +: 2] == 2'b00) full = 1'b0;
        return full ? 2'b11 : 2'b00;
    endfunction

    assign who0 = win_of(board0);
    assign who1 = win_of(board1);

    // ---------------- behavioural reference model ----------------
    // busy counts the cycles still owed to an accepted move:
    // 2 = write strobe cycle, 1 = result-sampling cycle, 0 = waiting.
    typedef struct {
        logic       play_q, pc_q, turn, over;
        logic       wr_en, illegal, timeout;
        logic [3:0] wr_pos;
        logic [1:0] wr_val;
        int         busy, count, timer;
    } model_t;

    model_t mdl [2];

    function automatic model_t model_reset(input logic fm);
        model_t m;
        m.play_q = 1'b0; m.pc_q = 1'b0; m.turn = fm; m.over = 1'b0;
        m.wr_en = 1'b0; m.illegal = 1'b0; m.timeout = 1'b0;
        m.wr_pos = 4'd0; m.wr_val = 2'b00;
        m.busy = 0; m.count = 0; m.timer = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input int limit,
                                          input logic [31:0] brd, input logic [1:0] w);
        model_t     n;
        bit         pr, cr, mine, other;
        logic [3:0] pos;
        n = m;
        pr = play && !m.play_q;
        cr = pc && !m.pc_q;
        n.play_q = play; n.pc_q = pc;
        n.wr_en = 1'b0; n.illegal = 1'b0; n.timeout = 1'b0;
        if (m.over) begin
            n.illegal = pr || cr;
        end else if (m.busy == 2) begin
            n.busy = 1;
        end else if (m.busy == 1) begin
            n.busy  = 0;
            n.timer = 0;
            if (w != 2'b00 || m.count == 16) n.over = 1'b1;
            else                             n.turn = !m.turn;
        end else begin
            mine  = m.turn ? cr : pr;
            other = m.turn ? pr : cr;
            pos   = m.turn ? computer_position : player_position;
            if (mine && brd[2*pos +: 2] == 2'b00) begin
                n.wr_en   = 1'b1;
                n.wr_pos  = pos;
                n.wr_val  = m.turn ? 2'b10 : 2'b01;
                n.count   = (m.count < 16) ? m.count + 1 : 16;
                n.busy    = 2;
                n.timer   = 0;
                n.illegal = other;
            end else begin
                n.illegal = mine || other;
                if (limit > 0 && m.timer == limit - 1) begin
                    n.timeout = 1'b1;
                    n.turn    = !m.turn;
                    n.timer   = 0;
                end else begin
                    n.timer = m.timer + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mdl[0] <= model_reset(1'b0);
            mdl[1] <= model_reset(1'b1);
        end else begin
            mdl[0] <= model_step(mdl[0], 15, board0, who0);
            mdl[1] <= model_step(mdl[1], 4, board1, who1);
        end
    end

    task automatic compare_model(input int k, input model_t m, input logic we,
                                 input logic [3:0] wp, input logic [1:0] wv, input logic tn,
                                 input logic il, input logic to, input logic go,
                                 input logic [4:0] mc);
        check($sformatf("d%0d wr_en", k),      we, m.wr_en);
        check($sformatf("d%0d illegal", k),    il, m.illegal);
        check($sformatf("d%0d timeout", k),    to, m.timeout);
        check($sformatf("d%0d turn", k),       tn, m.turn);
        check($sformatf("d%0d game_over", k),  go, m.over);
        check($sformatf("d%0d move_count", k), mc, 32'(m.count));
        if (m.wr_en) begin
            check($sformatf("d%0d wr_pos", k), wp, m.wr_pos);
            check($sformatf("d%0d wr_val", k), wv, m.wr_val);
        end
    endtask

    // Per-cycle model comparison, board writes and event counters.
    int         we_cnt0 = 0, we_cnt1 = 0, ill_cnt0 = 0, ill_cnt1 = 0;
    logic [1:0] last_val0 = 2'b00, last_val1 = 2'b00;

    always @(negedge clock) begin
        compare_model(0, mdl[0], wr_en0, wr_pos0, wr_val0, turn0, illegal0, timeout0,
                      game_over0, move_count0);
        compare_model(1, mdl[1], wr_en1, wr_pos1, wr_val1, turn1, illegal1, timeout1,
                      game_over1, move_count1);
        if (reset) begin
            board0 <= '0;
            board1 <= '0;
        end else begin
            if (wr_en0) begin
                board0[2*wr_pos0 +: 2] <= wr_val0;
                we_cnt0   <= we_cnt0 + 1;
                last_val0 <= wr_val0;
            end
            if (wr_en1) begin
                board1[2*wr_pos1 +: 2] <= wr_val1;
                we_cnt1   <= we_cnt1 + 1;
                last_val1 <= wr_val1;
            end
        end
        if (illegal0) ill_cnt0 <= ill_cnt0 + 1;
        if (illegal1) ill_cnt1 <= ill_cnt1 + 1;
    end

    // ---------------- stimulus ----------------
    int row_seq  [7]  = '{0, 4, 1, 5, 2, 6, 3};
    int cwin_seq [7]  = '{8, 0, 9, 1, 10, 2, 11};
    int draw_seq [16] = '{0, 2, 1, 3, 6, 4, 7, 5, 8, 10, 9, 11, 14, 12, 15, 13};

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        play = 1'b0;
        pc   = 1'b0;
        #2 reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Raise one side's request with a target, hold it, drop it, idle a cycle.
    task automatic move(input bit side, input logic [3:0] pos, input int hold);
        if (side) begin
            computer_position = pos;
            pc = 1'b1;
        end else begin
            player_position = pos;
            play = 1'b1;
        end
        tick(hold);
        play = 1'b0;
        pc   = 1'b0;
        tick(1);
    endtask

    int we_base, ill_base;

    initial begin
        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;

        // Reset values.
        #1;
        check("rst wr_en", wr_en0, 1'b0);
        check("rst wr_pos", wr_pos0, 4'd0);
        check("rst wr_val", wr_val0, 2'b00);
        check("rst turn0", turn0, 1'b0);
        check("rst turn1", turn1, 1'b1);
        check("rst illegal", illegal0, 1'b0);
        check("rst timeout", timeout0, 1'b0);
        check("rst game_over", game_over0, 1'b0);
        check("rst move_count", move_count0, 5'd0);

        // Player row win on dut0, each request held 5 cycles.
        we_base = we_cnt0; ill_base = ill_cnt0;
        for (int i = 0; i < 7; i++) move(i % 2 == 1, 4'(row_seq[i]), 5);
        #1;
        check("row wr_en pulses", we_cnt0 - we_base, 7);
        check("row no illegal", ill_cnt0 - ill_base, 0);
        check("row game_over", game_over0, 1'b1);
        check("row move_count", move_count0, 5'd7);
        check("row last wr_val", last_val0, 2'b01);
        we_base = we_cnt0; ill_base = ill_cnt0;
        move(1'b0, 4'd9, 2);
        #1;
        check("row done illegal", ill_cnt0 - ill_base, 1);
        check("row done no wr_en", we_cnt0 - we_base, 0);

        // Computer win on dut1 (computer moves first).
        do_reset();
        we_base = we_cnt1;
        for (int i = 0; i < 7; i++) move(i % 2 == 0, 4'(cwin_seq[i]), 3);
        #1;
        check("cwin wr_en pulses", we_cnt1 - we_base, 7);
        check("cwin game_over", game_over1, 1'b1);
        check("cwin move_count", move_count1, 5'd7);
        check("cwin last wr_val", last_val1, 2'b10);

        // Illegal moves on dut0.
        do_reset();
        move(1'b0, 4'd0, 3);
        #1 check("ill turn after p0", turn0, 1'b1);
        we_base = we_cnt0; ill_base = ill_cnt0;
        move(1'b1, 4'd0, 3);
        #1;
        check("ill occupied pulse", ill_cnt0 - ill_base, 1);
        check("ill occupied turn", turn0, 1'b1);
        check("ill occupied no wr_en", we_cnt0 - we_base, 0);
        move(1'b0, 4'd5, 3);
        #1;
        check("ill offturn pulse", ill_cnt0 - ill_base, 2);
        check("ill offturn no wr_en", we_cnt0 - we_base, 0);

        // Timeout cadence on dut1 (4 cycles): pulse every 4th edge, turn flips.
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            #1;
            check($sformatf("to pulse e%0d", e), timeout1, (e % 4) == 0);
            check($sformatf("to turn e%0d", e), turn1, 1'b1 ^ 1'((e / 4) % 2));
        end

        // Draw on dut0: 16 moves, no line completed.
        do_reset();
        for (int i = 0; i < 16; i++) move(i % 2 == 1, 4'(draw_seq[i]), 3);
        #1;
        check("draw game_over", game_over0, 1'b1);
        check("draw move_count", move_count0, 5'd16);
        check("draw last wr_val", last_val0, 2'b10);
        we_base = we_cnt0; ill_base = ill_cnt0;
        move(1'b0, 4'd0, 2);
        #1;
        check("draw done illegal", ill_cnt0 - ill_base, 1);
        check("draw done no wr_en", we_cnt0 - we_base, 0);

        // Reset during the write strobe of move 3; play held through release.
        do_reset();
        move(1'b0, 4'd0, 3);
        move(1'b1, 4'd4, 3);
        player_position = 4'd1;
        play = 1'b1;
        @(posedge clock);
        #1 check("mid wr_en before reset", wr_en0, 1'b1);
        reset = 1'b1;
        #1;
        check("mid wr_en dropped", wr_en0, 1'b0);
        check("mid move_count", move_count0, 5'd0);
        check("mid turn", turn0, 1'b0);
        check("mid game_over", game_over0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
        #1 check("held play after reset accepted", wr_en0, 1'b1);
        tick(2);
        play = 1'b0;

        // Randomized play with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            #2;
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) play = ~play;
            if ($urandom_range(0, 3) == 0) pc = ~pc;
            player_position   = 4'($urandom_range(0, 15));
            computer_position = 4'($urandom_range(0, 15));
        end
        #2 reset = 1'b0;
        play = 1'b0;
        pc   = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
